program_loader: RTL

Byte-stream program loader that writes 16-bit instruction words into instruction memory, the write-side counterpart to `program_counter`'s instruction fetch. It takes one byte per `i_valid` strobe from a byte source (UART receiver), parses a framed image, and drives a single-port write interface into the instruction RAM. While an image is in flight it asserts a hold so the CPU/program counter does not fetch partially written code.

---
 rtl/program_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: parses A5/LEN_HI/LEN_LO/data frames into 16-bit instruction RAM writes.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module program_loader #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_byte,
    input  logic                  i_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [15:0]           o_wr_data,
    output logic                  o_hold,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  SyncByte   = 8'hA5;
    localparam logic [31:0] MaxWords   = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StError
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              hi_q, hi_d;
    logic [TimerWidth-1:0]   timer_q, timer_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]             wr_data_q, wr_data_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif
    logic [31:0]             n_words;
    logic                    busy;

    assign busy = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StDataHi) ||
                  (state_q == StDataLo) || (state_q == StCheck);

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        timer_d   = timer_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        n_words   = {16'h0000, len_hi_q, i_byte};

        if (i_valid) begin
            timer_d = '0;
            case (state_q)
                StIdle, StError: begin
                    // Outside a frame only the sync byte matters; it starts a fresh image.
                    if (i_byte == SyncByte) begin
                        state_d = StLenHi;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        addr_d  = '0;
                        cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                StLenHi: begin
                    len_hi_d = i_byte;
                    state_d  = StLenLo;
                end
                StLenLo: begin
                    if ((n_words == 32'd0) || (n_words > MaxWords)) begin
                        state_d = StError;
                        error_d = 1'b1;
                    end else begin
                        len_d   = n_words[ADDR_WIDTH:0];
                        state_d = StDataHi;
                    end
                end
                StDataHi: begin
                    hi_d    = i_byte;
                    state_d = StDataLo;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ i_byte;
`endif
                end
                StDataLo: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {hi_q, i_byte};
                    addr_d    = addr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ i_byte;
`endif
                    if (cnt_d == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = StDataHi;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (i_byte == csum_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end else if (busy) begin
            // A byte in the same cycle always wins over the timeout, so only idle cycles count.
            if (timer_q == TimerWidth'(TIMEOUT_CYCLES - 1)) begin
                state_d = StError;
                error_d = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= StIdle;
            len_hi_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            hi_q      <= '0;
            timer_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            timer_q   <= timer_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_hold    = busy;
    assign o_done    = done_q;
    assign o_error   = error_q;

endmodule
